// File: rtl/spm_burst_loader.sv
// rtl/spm_burst_loader.sv - burst loader writing a source stream into SPM bank groups
// Optional macro SPM_LOADER_STRIDE_EN: advance addresses by the latched cmd_stride instead of 1.
module spm_burst_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BG_W   = 2,
    parameter int LEN_W  = 8,
    localparam int NUM_BG = 2 ** BG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BG_W-1:0]   cmd_bg,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              ex_wen,
    output logic [ADDR_W-1:0] ex_addr,
    output logic [DATA_W-1:0] ex_data,
    output logic [NUM_BG-1:0] bg_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [NUM_BG-1:0] BG_ONE = NUM_BG'(1);

    state_t            state;
    logic [BG_W-1:0]   bg_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] step;

`ifdef SPM_LOADER_STRIDE_EN
    assign step = stride_q;
`else
    // Unit-stride build: the stride input and its latch carry no function.
    logic unused_stride;
    assign unused_stride = ^{cmd_stride, stride_q};
    assign step = ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            src_ready <= 1'b0;
            ex_wen    <= 1'b0;
            bg_en     <= '0;
            ex_addr   <= '0;
            ex_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bg_q      <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            stride_q  <= '0;
        end else begin
            ex_wen <= 1'b0;
            bg_en  <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        bg_q      <= cmd_bg;
                        cur_addr  <= cmd_base;
                        remaining <= cmd_len;
                        stride_q  <= cmd_stride;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= BURST;
                            src_ready <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (src_valid) begin
                        ex_wen    <= 1'b1;
                        ex_addr   <= cur_addr;
                        ex_data   <= src_data;
                        bg_en     <= BG_ONE << bg_q;
                        cur_addr  <= cur_addr + step;
                        remaining <= remaining - LEN_W'(1);
                        // Last beat: the final write and the done pulse share a cycle.
                        if (remaining == LEN_W'(1)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            src_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
